// File: rtl/div_unit_seq.sv
// Multi-cycle RV32M/RV64M divider (DIV, DIVU, REM, REMU) for the EX stage.
// Restoring shift-subtract core that retires UNROLL quotient bits per cycle, with valid/ready on both sides.
module div_unit_seq #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITERS = XLEN / UNROLL;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_SPECIAL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fix_ph_q, fix_ph_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              spec_zero_q, spec_zero_d;

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   signed_op, rs1_neg, rs2_neg, div_zero, overflow;
    logic [XLEN-1:0]        quo_step, rem_step;
    logic [XLEN:0]          shift_v, diff_v;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    // Two's-complement magnitude; the most negative value maps onto unsigned 2^(XLEN-1).
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    assign rs1_s     = rs1;
    assign rs2_s     = rs2;
    assign signed_op = ~op[0];
    assign rs1_neg   = signed_op & rs1_s[XLEN-1];
    assign rs2_neg   = signed_op & rs2_s[XLEN-1];
    assign div_zero  = (rs2 == '0);
    assign overflow  = signed_op && (rs1 == MIN_VAL) && (rs2 == '1);

    // Restoring core: quo_q doubles as the dividend shift register, quotient bits enter at the LSB.
    always_comb begin
        quo_step = quo_q;
        rem_step = rem_q;
        shift_v  = '0;
        diff_v   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            shift_v  = {rem_step, quo_step[XLEN-1]};
            quo_step = {quo_step[XLEN-2:0], 1'b0};
            diff_v   = shift_v - {1'b0, dvsr_q};
            if (!diff_v[XLEN]) begin
                rem_step    = diff_v[XLEN-1:0];
                quo_step[0] = 1'b1;
            end else begin
                rem_step = shift_v[XLEN-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fix_ph_d    = fix_ph_q;
        op_d        = op_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        spec_zero_d = spec_zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !kill) begin
                    op_d = op;
                    if (div_zero || overflow) begin
                        state_d     = S_SPECIAL;
                        quo_d       = rs1;
                        spec_zero_d = div_zero;
                    end else begin
                        state_d   = S_CALC;
                        quo_d     = magnitude(rs1_s, rs1_neg);
                        dvsr_d    = magnitude(rs2_s, rs2_neg);
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = rs1_neg ^ rs2_neg;
                        neg_rem_d = rs1_neg;
                    end
                end
            end
            S_CALC: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_FIX;
                    fix_ph_d = 1'b0;
                end
            end
            S_FIX: begin
                // Sign correction and result selection sit in separate cycles to keep the negate off the mux path.
                if (!fix_ph_q) begin
                    quo_d    = cond_negate(quo_q, neg_quo_q);
                    rem_d    = cond_negate(rem_q, neg_rem_q);
                    fix_ph_d = 1'b1;
                end else begin
                    result_d = op_q[1] ? rem_q : quo_q;
                    state_d  = S_DONE;
                end
            end
            S_SPECIAL: begin
                if (spec_zero_q) begin
                    result_d = op_q[1] ? quo_q : '1;
                end else begin
                    result_d = op_q[1] ? '0 : MIN_VAL;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fix_ph_q    <= 1'b0;
            op_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            spec_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fix_ph_q    <= fix_ph_d;
            op_q        <= op_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            spec_zero_q <= spec_zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Bench for div_unit_seq: a 32-bit/UNROLL=1 instance and a 64-bit/UNROLL=4 instance,
// checked against an arithmetic reference model of the RISC-V divide rules.
module tb_div_unit_seq;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid_n, in_ready_n, kill_n, out_valid_n, out_ready_n, busy_n;
    logic [1:0]  op_n;
    logic [31:0] rs1_n, rs2_n, result_n;

    logic        in_valid_w, in_ready_w, kill_w, out_valid_w, out_ready_w, busy_w;
    logic [1:0]  op_w;
    logic [63:0] rs1_w, rs2_w, result_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit_seq #(.XLEN(32), .UNROLL(1)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n), .op(op_n),
        .rs1(rs1_n), .rs2(rs2_n), .kill(kill_n), .out_valid(out_valid_n),
        .out_ready(out_ready_n), .result(result_n), .busy(busy_n)
    );

    div_unit_seq #(.XLEN(64), .UNROLL(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .op(op_w),
        .rs1(rs1_w), .rs2(rs2_w), .kill(kill_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .result(result_w), .busy(busy_w)
    );

    localparam int ND = 10;
    logic [1:0]  d_op  [ND] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] d_a   [ND] = '{32'd84, 32'hFFFF_FFAC, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'd7, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] d_b   [ND] = '{32'd12, 32'd12, 32'd4, 32'd10, 32'd2,
                                32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] d_exp [ND] = '{32'd7, 32'hFFFF_FFF9, 32'd25, 32'd5, 32'hFFFF_FFFF,
                                32'd1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
    int          d_lat [ND] = '{34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

    // Reference: RISC-V divide semantics computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                              input bit wide);
        longint      sa, sb;
        logic [63:0] ua, ub, r, min_v, ones;
        if (wide) begin
            ua = a; ub = b; sa = a; sb = b;
            min_v = 64'h8000_0000_0000_0000; ones = '1;
        end else begin
            ua = {32'b0, a[31:0]}; ub = {32'b0, b[31:0]};
            sa = longint'($signed(a[31:0])); sb = longint'($signed(b[31:0]));
            min_v = 64'h0000_0000_8000_0000; ones = 64'h0000_0000_FFFF_FFFF;
        end
        if (ub == 0) begin
            r = o[1] ? ua : ones;
        end else if (wide && !o[0] && ua == min_v && sb == -1) begin
            r = o[1] ? 64'd0 : min_v;
        end else begin
            case (o)
                2'b00:   r = 64'(sa / sb);
                2'b01:   r = ua / ub;
                2'b10:   r = 64'(sa % sb);
                default: r = ua % ub;
            endcase
        end
        if (!wide) r[63:32] = '0;
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input bit wide);
        logic [63:0] min_v, ones, ua, ub;
        min_v = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        ones  = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ua    = wide ? a : {32'b0, a[31:0]};
        ub    = wide ? b : {32'b0, b[31:0]};
        if (ub == 0) return 1;
        if (!o[0] && ua == min_v && ub == ones) return 1;
        return wide ? (64 / 4 + 2) : (32 / 1 + 2);
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'($urandom_range(0, 20));
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = '1;
            3:       v = {$urandom, $urandom};
            4:       v = {$urandom, $urandom} >> $urandom_range(1, 62);
            default: v = -64'($urandom_range(1, 20));
        endcase
        return v;
    endfunction

    function automatic logic get_ovalid(input bit wide);
        return wide ? out_valid_w : out_valid_n;
    endfunction

    function automatic logic get_iready(input bit wide);
        return wide ? in_ready_w : in_ready_n;
    endfunction

    function automatic logic [63:0] get_result(input bit wide);
        return wide ? result_w : {32'b0, result_n};
    endfunction

    task automatic set_in(input bit wide, input logic v, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        if (wide) begin
            in_valid_w = v; op_w = o; rs1_w = a; rs2_w = b;
        end else begin
            in_valid_n = v; op_n = o; rs1_n = a[31:0]; rs2_n = b[31:0];
        end
    endtask

    task automatic set_ready(input bit wide, input logic v);
        if (wide) out_ready_w = v; else out_ready_n = v;
    endtask

    task automatic pulse_kill(input bit wide);
        @(negedge clk);
        if (wide) kill_w = 1'b1; else kill_n = 1'b1;
        @(posedge clk); #1;
        kill_w = 1'b0; kill_n = 1'b0;
    endtask

    // One full transaction; operands are scrambled right after acceptance.
    task automatic do_op(input bit wide, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] res, output int lat);
        @(negedge clk);
        n_checks++;
        if (get_iready(wide) !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_before_accept: got %b expected 1", get_iready(wide));
        end
        set_in(wide, 1'b1, o, a, b);
        @(posedge clk); #1;
        set_in(wide, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        lat = 0;
        while (!get_ovalid(wide) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_result(wide);
        if (lat >= 200) begin
            pulse_kill(wide);
        end else begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            set_ready(wide, 1'b1);
            @(posedge clk); #1;
            set_ready(wide, 1'b0);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready_n !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready_n: got %b expected 1", in_ready_n); end
        n_checks++; if (out_valid_n !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid_n: got %b expected 0", out_valid_n); end
        n_checks++; if (busy_n !== 1'b0)       begin n_fail++; $display("FAIL reset_busy_n: got %b expected 0", busy_n); end
        n_checks++; if (result_n !== 32'd0)    begin n_fail++; $display("FAIL reset_result_n: got %h expected 0", result_n); end
        n_checks++; if (in_ready_w !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready_w: got %b expected 1", in_ready_w); end
        n_checks++; if (out_valid_w !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid_w: got %b expected 0", out_valid_w); end
        n_checks++; if (busy_w !== 1'b0)       begin n_fail++; $display("FAIL reset_busy_w: got %b expected 0", busy_w); end
        n_checks++; if (result_w !== 64'd0)    begin n_fail++; $display("FAIL reset_result_w: got %h expected 0", result_w); end
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int          lat;
        for (int i = 0; i < ND; i++) begin
            do_op(1'b0, d_op[i], {32'b0, d_a[i]}, {32'b0, d_b[i]}, 0, res, lat);
            n_checks++;
            if (res !== {32'b0, d_exp[i]}) begin
                n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_exp[i]);
            end
            n_checks++;
            if (lat !== d_lat[i]) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_lat[i]);
            end
        end
    endtask

    task automatic test_hold_back_to_back();
        int w;
        @(negedge clk);
        set_in(1'b0, 1'b1, 2'b00, 64'd1000, 64'd7);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        w = 0;
        while (!out_valid_n && w < 60) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (result_n !== 32'd142) begin n_fail++; $display("FAIL hold_first_result: got %h expected %h", result_n, 32'd142); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_in(1'b0, 1'b1, 2'b01, 64'd50, 64'd5);
            @(posedge clk); #1;
            n_checks++; if (out_valid_n !== 1'b1)   begin n_fail++; $display("FAIL hold_out_valid[%0d]: got %b expected 1", c, out_valid_n); end
            n_checks++; if (result_n !== 32'd142)   begin n_fail++; $display("FAIL hold_result[%0d]: got %h expected %h", c, result_n, 32'd142); end
            n_checks++; if (in_ready_n !== 1'b0)    begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready_n); end
        end
        @(negedge clk);
        out_ready_n = 1'b1;
        @(posedge clk); #1;
        out_ready_n = 1'b0;
        n_checks++; if (out_valid_n !== 1'b0) begin n_fail++; $display("FAIL handshake_out_valid: got %b expected 0", out_valid_n); end
        n_checks++; if (in_ready_n !== 1'b1)  begin n_fail++; $display("FAIL handshake_in_ready: got %b expected 1", in_ready_n); end
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        n_checks++; if (busy_n !== 1'b1) begin n_fail++; $display("FAIL back_to_back_accept: got busy=%b expected 1", busy_n); end
        w = 0;
        while (!out_valid_n && w < 60) begin @(posedge clk); #1; w++; end
        n_checks++; if (result_n !== 32'd10) begin n_fail++; $display("FAIL back_to_back_result: got %h expected %h", result_n, 32'd10); end
        @(negedge clk);
        out_ready_n = 1'b1;
        @(posedge clk); #1;
        out_ready_n = 1'b0;
    endtask

    task automatic test_kill();
        int seen, w;
        @(negedge clk);
        set_in(1'b0, 1'b1, 2'b00, 64'd1000, 64'd3);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (9) @(posedge clk);
        pulse_kill(1'b0);
        n_checks++; if (busy_n !== 1'b0)      begin n_fail++; $display("FAIL kill_calc_busy: got %b expected 0", busy_n); end
        n_checks++; if (in_ready_n !== 1'b1)  begin n_fail++; $display("FAIL kill_calc_in_ready: got %b expected 1", in_ready_n); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid_n) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL kill_calc_no_valid: got %0d valid cycles expected 0", seen); end

        @(negedge clk);
        set_in(1'b0, 1'b1, 2'b11, 64'd1000, 64'd3);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        w = 0;
        while (!out_valid_n && w < 60) begin @(posedge clk); #1; w++; end
        n_checks++; if (out_valid_n !== 1'b1) begin n_fail++; $display("FAIL kill_done_reach: got %b expected 1", out_valid_n); end
        pulse_kill(1'b0);
        n_checks++; if (out_valid_n !== 1'b0) begin n_fail++; $display("FAIL kill_done_drop: got %b expected 0", out_valid_n); end
        n_checks++; if (in_ready_n !== 1'b1)  begin n_fail++; $display("FAIL kill_done_in_ready: got %b expected 1", in_ready_n); end

        @(negedge clk);
        set_in(1'b0, 1'b1, 2'b01, 64'd20, 64'd4);
        kill_n = 1'b1;
        @(posedge clk); #1;
        kill_n = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        n_checks++; if (busy_n !== 1'b0) begin n_fail++; $display("FAIL kill_overrides_accept: got busy=%b expected 0", busy_n); end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        set_in(1'b0, 1'b1, 2'b00, 64'd5000, 64'd7);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy_n !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_n); end
        n_checks++; if (in_ready_n !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready_n); end
        n_checks++; if (out_valid_n !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid_n); end
        n_checks++; if (result_n !== 32'd0)   begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result_n); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (out_valid_n !== 1'b0) begin n_fail++; $display("FAIL midrst_no_residual_valid: got %b expected 0", out_valid_n); end
    endtask

    task automatic test_random(input bit wide, input int count);
        logic [63:0] a, b, res, exp_r;
        logic [1:0]  o;
        int          lat, exp_l;
        for (int i = 0; i < count; i++) begin
            o = 2'($urandom_range(0, 3));
            a = rand_operand();
            b = rand_operand();
            if (i % 25 == 3) b = 64'd0;
            if (i % 40 == 7) begin
                a = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                b = '1;
                o = {1'($urandom), 1'b0};
            end
            if (!wide) begin a[63:32] = '0; b[63:32] = '0; end
            exp_r = ref_model(o, a, b, wide);
            exp_l = ref_lat(o, a, b, wide);
            do_op(wide, o, a, b, $urandom_range(0, 2), res, lat);
            n_checks++;
            if (res !== exp_r) begin
                n_fail++;
                $display("FAIL random%s_result[%0d]: op=%0d a=%h b=%h got %h expected %h",
                         wide ? "64" : "32", i, o, a, b, res, exp_r);
            end
            n_checks++;
            if (lat !== exp_l) begin
                n_fail++;
                $display("FAIL random%s_latency[%0d]: got %0d expected %0d", wide ? "64" : "32", i, lat, exp_l);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        set_in(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
        kill_n = 1'b0; kill_w = 1'b0;
        out_ready_n = 1'b0; out_ready_w = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_hold_back_to_back();
        test_kill();
        test_reset_mid_calc();
        test_random(1'b0, 300);
        test_random(1'b1, 1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
